dut_stress_harness: RTL

- Synthesizable, parametrised stimulus/checker harness that drives any start/finish-handshake datapath block (AES128_encrypt and its successors) back-to-back with pseudorandom data and key words.
- Replaces free-running testbench generators with per-lane xorshift32 sources, an iteration limit, a fixed/rolling key mode, a timeout watchdog and a running output signature for golden-value comparison.
- Sits between the bench top and the DUT.

---
 rtl/dut_stress_harness.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dut_stress_harness.sv
// Stimulus/checker harness: drives a start/finish-handshake block back-to-back with
// xorshift32 data and key words, counts operations, signs results and watches for hangs.
module dut_stress_harness #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned KEY_W      = 128,
    parameter int unsigned OUT_W      = 128,
    parameter logic [31:0] SEED_DATA  = 32'h1,
    parameter logic [31:0] SEED_KEY   = 32'hACE1,
    parameter int unsigned KEY_MODE   = 0,
    parameter int unsigned ITERATIONS = 0,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              dut_start,
    output logic [DATA_W-1:0] dut_in,
    output logic [KEY_W-1:0]  dut_key,
    input  logic              dut_finish,
    input  logic [OUT_W-1:0]  dut_out,
    output logic [OUT_W-1:0]  signature,
    output logic [31:0]       iter_count,
    output logic              done,
    output logic              timeout_err
);

    localparam int unsigned DATA_LANES = DATA_W / 32;
    localparam int unsigned KEY_LANES  = KEY_W / 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_e;

    // Lanes are decorrelated by a golden-ratio offset; an all-zero xorshift state would stick.
    function automatic logic [31:0] lane_seed(input logic [31:0] base, input int unsigned lane);
        logic [31:0] idx;
        logic [31:0] s;
        idx = 32'(lane);
        s   = base ^ (idx * 32'h9E3779B9);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [31:0] xorshift32(input logic [31:0] x_in);
        logic [31:0] x;
        x = x_in;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    function automatic logic [DATA_W-1:0] data_seeds();
        logic [DATA_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DATA_LANES; i++) v[i*32 +: 32] = lane_seed(SEED_DATA, i);
        return v;
    endfunction

    function automatic logic [KEY_W-1:0] key_seeds();
        logic [KEY_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < KEY_LANES; i++) v[i*32 +: 32] = lane_seed(SEED_KEY, i);
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] step_data(input logic [DATA_W-1:0] v_in);
        logic [DATA_W-1:0] v;
        v = v_in;
        for (int unsigned i = 0; i < DATA_LANES; i++) v[i*32 +: 32] = xorshift32(v_in[i*32 +: 32]);
        return v;
    endfunction

    function automatic logic [KEY_W-1:0] step_key(input logic [KEY_W-1:0] v_in);
        logic [KEY_W-1:0] v;
        v = v_in;
        for (int unsigned i = 0; i < KEY_LANES; i++) v[i*32 +: 32] = xorshift32(v_in[i*32 +: 32]);
        return v;
    endfunction

    localparam logic [DATA_W-1:0] DATA_SEED = data_seeds();
    localparam logic [KEY_W-1:0]  KEY_SEED  = key_seeds();

    state_e            state_q;
    logic              start_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] data_q, data_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [OUT_W-1:0]  sig_q, sig_d;
    logic [31:0]       iter_q, iter_d;
    logic [31:0]       timer_q, timer_d;
    logic              last_op;
    logic              timer_expired;

    assign data_d        = step_data(data_q);
    assign key_d         = (KEY_MODE == 0) ? step_key(key_q) : key_q;
    assign sig_d         = ((sig_q << 1) | (sig_q >> (OUT_W - 1))) ^ dut_out;
    assign iter_d        = iter_q + 32'd1;
    assign timer_d       = timer_q + 32'd1;
    assign last_op       = (ITERATIONS != 0) && (iter_d == 32'(ITERATIONS));
    assign timer_expired = (TIMEOUT != 0) && (timer_d == 32'(TIMEOUT));

    // NOTE: every register, generator state included, has an async reset so a mid-run reset
    // replays the exact same stimulus sequence from the seeds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= DATA_SEED;
            key_q   <= KEY_SEED;
            sig_q   <= '0;
            iter_q  <= '0;
            timer_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    timer_q <= timer_d;
                    // A finish on the expiry cycle still counts as a completed operation.
                    if (dut_finish) begin
                        sig_q  <= sig_d;
                        iter_q <= iter_d;
                        data_q <= data_d;
                        key_q  <= key_d;
                        if (last_op) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (enable) begin
                            state_q <= ISSUE;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (timer_expired) begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                    end
                end
                DONE, ERROR: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dut_start   = start_q;
    assign dut_in      = data_q;
    assign dut_key     = key_q;
    assign signature   = sig_q;
    assign iter_count  = iter_q;
    assign done        = done_q;
    assign timeout_err = err_q;

endmodule
